// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and frame helpers for the UART transmitter
package uart_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam int FRAME_MAX = 11;
  localparam int BAUD_W    = 19;
  localparam int IDX_W     = $clog2(FRAME_MAX + 1);

  // Everything latched at the load edge; the frame in flight depends only on this.
  typedef struct packed {
    logic [7:0]        data;
    logic              eight;
    logic              pen;
    logic              ohel;
    logic [BAUD_W-1:0] baud;
  } frame_t;

  // Total bits on the wire: start + data + optional parity + stop.
  function automatic logic [IDX_W-1:0] frame_len(frame_t f);
    return 4'd2 + (f.eight ? 4'd8 : 4'd7) + {3'b000, f.pen};
  endfunction

  // Line level for bit position idx of the frame (0 = start bit).
  function automatic logic frame_bit(frame_t f, logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] n;
    logic [7:0]       d;
    logic [2:0]       di;
    logic             par;
    n   = f.eight ? 4'd8 : 4'd7;
    // In 7-bit mode the top data bit is masked so it cannot leak into parity.
    d   = f.eight ? f.data : {1'b0, f.data[6:0]};
    par = (^d) ^ f.ohel;
    di  = 3'(idx - 4'd1);
    if (idx == 4'd0)
      return 1'b0;
    else if (idx <= n)
      return d[di];
    else if (f.pen && (idx == n + 4'd1))
      return par;
    else
      return 1'b1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-time counter with one-cycle wrap strobe
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              wrap
);

  logic [BAUD_W-1:0] cnt;

  assign wrap = en && (cnt == baud_k - 1'b1);

  // Count 0..baud_k-1 while enabled; parked at zero otherwise so every frame starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!en || wrap)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: start, 7/8 data bits, optional parity, stop
module uart_tx_engine
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              tx,
  output logic              txrdy,
  output logic              tx_done
);

  state_t           state;
  frame_t           frame;
  logic [IDX_W-1:0] bit_idx;
  logic             wrap;

  uart_bit_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == SEND),
    .baud_k (frame.baud),
    .wrap   (wrap)
  );

  // Frame FSM: capture on load in IDLE, step one bit per timer wrap, finish on the stop-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      frame   <= '1;
      bit_idx <= '0;
      tx      <= 1'b1;
      txrdy   <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            frame.data  <= out_port;
            frame.eight <= eight;
            frame.pen   <= pen;
            frame.ohel  <= ohel;
            frame.baud  <= baud_k;
            bit_idx     <= '0;
            tx          <= 1'b0;
            txrdy       <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          // load is deliberately not looked at here: a write during a frame is dropped.
          if (wrap) begin
            if (bit_idx == frame_len(frame) - 4'd1) begin
              state   <= IDLE;
              bit_idx <= '0;
              tx      <= 1'b1;
              txrdy   <= 1'b1;
              tx_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= frame_bit(frame, bit_idx + 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench for uart_tx_engine
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [7:0]  out_port;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [18:0] baud_k;
  logic        tx;
  logic        txrdy;
  logic        tx_done;

  uart_tx_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .out_port (out_port),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .baud_k   (baud_k),
    .tx       (tx),
    .txrdy    (txrdy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:10] bits;
    int          len;
    int          baud;
    bit          b2b;
    bit          abort;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [7:0] d, input logic e8, input logic p, input logic o,
                       input int bk, input logic [0:10] bits, input int len,
                       input bit b2b, input bit ab);
    exp_t x;
    x.bits = bits; x.len = len; x.baud = bk; x.b2b = b2b; x.abort = ab;
    exp_q.push_back(x);
    out_port = d; eight = e8; pen = p; ohel = o; baud_k = 19'(bk); load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    out_port = 8'h00; eight = ~e8; pen = ~p; ohel = ~o; baud_k = 19'd7;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (txrdy !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (txrdy !== 1'b1) check({name, "_idle_timeout"}, txrdy, 1);
  endtask

  // Monitor: on every frame start pop the expected frame and compare it bit by bit.
  initial begin : monitor
    exp_t e;
    int   start_cyc;
    int   done_cyc;
    int   fno;
    int   bad;
    int   n;
    logic got;
    bit   aborted;
    done_cyc = -100;
    fno = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txrdy === 1'b0) begin
        mon_busy = 1;
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame tx=%b at cycle %0d required no frame", tx, cyc);
          n = 0;
          while (txrdy === 1'b0 && rst_n === 1'b1 && n < 20000) begin
            @(negedge clk); n++;
          end
        end else begin
          e = exp_q.pop_front();
          if (e.b2b) check($sformatf("frame%0d_b2b_start", fno), start_cyc, done_cyc + 1);
          aborted = 0;
          for (int b = 0; b < e.len && !aborted; b++) begin
            bad = 0;
            got = tx;
            for (int c = 0; c < e.baud; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_n !== 1'b1) begin
                aborted = 1;
                break;
              end
              if (tx !== e.bits[b] || txrdy !== 1'b0 || tx_done !== 1'b0) begin
                bad++;
                got = tx;
              end
            end
            if (!aborted) begin
              checks++;
              if (bad != 0) begin
                errors++;
                $display("FAIL frame%0d_bit%0d actual tx=%b txrdy=%b tx_done=%b required tx=%b txrdy=0 tx_done=0",
                         fno, b, got, txrdy, tx_done, e.bits[b]);
              end
            end
          end
          if (aborted) begin
            check($sformatf("frame%0d_abort_expected", fno), 1, {31'd0, e.abort});
          end else begin
            check($sformatf("frame%0d_abort_missing", fno), 0, {31'd0, e.abort});
            @(negedge clk);
            check($sformatf("frame%0d_done", fno), {tx_done, txrdy, tx}, 3'b111);
            done_cyc = cyc;
          end
        end
        fno++;
        mon_busy = 0;
      end
    end
  end

  initial begin : stimulus
    int n;
    load = 1'b0; out_port = 8'h00; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    baud_k = 19'd4; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_txrdy", txrdy, 1);
    check("reset_tx_done", tx_done, 0);
    rst_n = 1'b1;

    // 8N1, A5, 4 cycles per bit
    issue(8'hA5, 1'b1, 1'b0, 1'b0, 4, 11'b0_10100101_1_1, 10, 0, 0);
    wait_idle("a5");
    // 8E1, 07: three ones -> even parity bit 1
    issue(8'h07, 1'b1, 1'b1, 1'b0, 3, 11'b0_11100000_1_1, 11, 0, 0);
    wait_idle("07");
    // 7O1, FF: seven ones -> odd parity bit 0, bit 7 dropped
    issue(8'hFF, 1'b0, 1'b1, 1'b1, 3, 11'b0_1111111_0_1_1, 10, 0, 0);
    wait_idle("ff");
    // 3C frame with a stray load of 55 during its data bits
    issue(8'h3C, 1'b1, 1'b0, 1'b0, 5, 11'b0_00111100_1_1, 10, 0, 0);
    repeat (12) @(posedge clk);
    #1;
    out_port = 8'h55; eight = 1'b1; pen = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("ignored_load_txrdy", txrdy, 0);
    wait_idle("3c");
    // Back-to-back: 8O1 5A, then 7N1 C3 loaded in the tx_done cycle
    issue(8'h5A, 1'b1, 1'b1, 1'b1, 2, 11'b0_01011010_1_1, 11, 0, 0);
    n = 0;
    while (tx_done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_tx_done_seen", tx_done, 1);
    issue(8'hC3, 1'b0, 1'b0, 1'b0, 2, 11'b0_1100001_1_11, 9, 1, 0);
    wait_idle("c3");
    // Reset during the 4th data bit of 96, then a clean 81 frame
    issue(8'h96, 1'b1, 1'b0, 1'b0, 4, 11'b0_01101001_1_1, 10, 0, 1);
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_txrdy", txrdy, 1);
    check("abort_tx_done", tx_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(8'h81, 1'b1, 1'b0, 1'b0, 3, 11'b0_10000001_1_1, 10, 0, 0);
    wait_idle("81");

    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    check("final_idle_tx", tx, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
